// File: rtl/add_4_pkg.sv
// rtl/add_4_pkg.sv - shared widths and arithmetic reference for the four-operand adder
package add_4_pkg;

    localparam int ADD4_WIDTH = 4;
    localparam int SUM_W      = ADD4_WIDTH + 2;

    // Returns {ov, sum} for the default operand width.
    function automatic logic [ADD4_WIDTH:0] ref_add4(
        input logic [ADD4_WIDTH-1:0] a,
        input logic [ADD4_WIDTH-1:0] b,
        input logic [ADD4_WIDTH-1:0] c,
        input logic [ADD4_WIDTH-1:0] d
    );
        logic [SUM_W-1:0] total;
        total = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
        return {|total[SUM_W-1:ADD4_WIDTH], total[ADD4_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/add_4_full_adder.sv
// rtl/add_4_full_adder.sv - one-bit full adder used by the carry-save and ripple stages
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/add_4.sv
// rtl/add_4.sv - registered four-operand unsigned adder with overflow flag
module add_4
    import add_4_pkg::*;
#(
    parameter int WIDTH = ADD4_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sum,
    output logic             ov
);

    localparam int TW = WIDTH + 2;

    logic [WIDTH-1:0] w_s1;
    logic [WIDTH-1:0] w_c1;
    logic [WIDTH:0]   w_s1x;
    logic [WIDTH:0]   w_c1x;
    logic [WIDTH:0]   w_dx;
    logic [WIDTH:0]   w_s2;
    logic [WIDTH:0]   w_c2;
    logic [TW-1:0]    w_s2x;
    logic [TW-1:0]    w_c2x;
    logic [TW-1:0]    w_rc;
    logic [TW-1:0]    w_total;
    logic [WIDTH-1:0] r_sum;
    logic             r_ov;

    // Stage 1: compress a, b, c into a sum word and a carry word.
    for (genvar i = 0; i < WIDTH; i++) begin : g_csa1
        full_adder u_fa (
            .x    (a[i]),
            .y    (b[i]),
            .cin  (c[i]),
            .s    (w_s1[i]),
            .cout (w_c1[i])
        );
    end

    assign w_s1x = {1'b0, w_s1};
    assign w_c1x = {w_c1, 1'b0};
    assign w_dx  = {1'b0, d};

    // Stage 2: fold d into the stage-1 result, one bit wider to hold the shifted carry.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_csa2
        full_adder u_fa (
            .x    (w_s1x[i]),
            .y    (w_c1x[i]),
            .cin  (w_dx[i]),
            .s    (w_s2[i]),
            .cout (w_c2[i])
        );
    end

    assign w_s2x = {1'b0, w_s2};
    assign w_c2x = {w_c2, 1'b0};
    assign w_rc[0] = 1'b0;

    for (genvar i = 0; i < TW - 1; i++) begin : g_ripple
        full_adder u_fa (
            .x    (w_s2x[i]),
            .y    (w_c2x[i]),
            .cin  (w_rc[i]),
            .s    (w_total[i]),
            .cout (w_rc[i+1])
        );
    end

    // The total never exceeds TW bits, so the top carry-out is not needed.
    assign w_total[TW-1] = w_s2x[TW-1] ^ w_c2x[TW-1] ^ w_rc[TW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
            r_ov  <= 1'b0;
        end else begin
            r_sum <= w_total[WIDTH-1:0];
            r_ov  <= |w_total[TW-1:WIDTH];
        end
    end

    assign sum = r_sum;
    assign ov  = r_ov;

endmodule

// File: tb/tb_add_4.sv
// tb/tb_add_4.sv - self-checking bench for the registered four-operand adder
module tb_add_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic [W-1:0] d = '0;
    logic [W-1:0] sum;
    logic         ov;

    int n_checks = 0;
    int n_errors = 0;

    add_4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sum (sum),
        .ov  (ov)
    );

    always #5 clk = ~clk;

    function automatic int exp_sum(input int ia, input int ib, input int ic, input int id);
        return (ia + ib + ic + id) % (1 << W);
    endfunction

    function automatic logic exp_ov(input int ia, input int ib, input int ic, input int id);
        return (ia + ib + ic + id) >= (1 << W);
    endfunction

    task automatic drive(input int ia, input int ib, input int ic, input int id);
        @(negedge clk);
        a = W'(ia);
        b = W'(ib);
        c = W'(ic);
        d = W'(id);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a = 4'd15; b = 4'd15; c = 4'd15; d = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (sum !== 4'd0 || ov !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: sum=%0d ov=%b, want sum=0 ov=0", i, sum, ov);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (sum !== 4'd12 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: sum=%0d ov=%b, want sum=12 ov=1", sum, ov);
        end
    endtask

    task automatic test_no_overflow();
        drive(15, 0, 0, 0);
        n_checks++;
        if (sum !== 4'd15 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL no_ov_15: sum=%0d ov=%b, want sum=15 ov=0", sum, ov);
        end
        drive(3, 4, 5, 2);
        n_checks++;
        if (sum !== 4'd14 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL no_ov_14: sum=%0d ov=%b, want sum=14 ov=0", sum, ov);
        end
    endtask

    task automatic test_overflow_boundary();
        drive(15, 1, 0, 0);
        n_checks++;
        if (sum !== 4'd0 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL boundary_16: sum=%0d ov=%b, want sum=0 ov=1", sum, ov);
        end
        drive(8, 4, 2, 1);
        n_checks++;
        if (sum !== 4'd15 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL boundary_15: sum=%0d ov=%b, want sum=15 ov=0", sum, ov);
        end
    endtask

    task automatic test_maximum();
        drive(15, 15, 15, 15);
        n_checks++;
        if (sum !== 4'd12 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL max_all15: sum=%0d ov=%b, want sum=12 ov=1", sum, ov);
        end
        drive(8, 8, 8, 8);
        n_checks++;
        if (sum !== 4'd0 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL max_all8: sum=%0d ov=%b, want sum=0 ov=1", sum, ov);
        end
        drive(0, 0, 0, 0);
        n_checks++;
        if (sum !== 4'd0 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL all_zero: sum=%0d ov=%b, want sum=0 ov=0", sum, ov);
        end
    endtask

    task automatic test_random();
        int ra, rb, rc, rd;
        for (int i = 0; i < 300; i++) begin
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            rc = int'($urandom_range(15, 0));
            rd = int'($urandom_range(15, 0));
            drive(ra, rb, rc, rd);
            n_checks++;
            if (int'(sum) != exp_sum(ra, rb, rc, rd) || ov !== exp_ov(ra, rb, rc, rd)) begin
                n_errors++;
                $display("FAIL random %0d+%0d+%0d+%0d: sum=%0d ov=%b, want sum=%0d ov=%b",
                         ra, rb, rc, rd, sum, ov, exp_sum(ra, rb, rc, rd), exp_ov(ra, rb, rc, rd));
            end
        end
    endtask

    task automatic test_sweep_with_reset();
        int va, vb, vc, vd;
        for (int n = 0; n < 65536; n++) begin
            va = n % 16;
            vb = (n / 16) % 16;
            vc = (n / 256) % 16;
            vd = (n / 4096) % 16;
            drive(va, vb, vc, vd);
            n_checks++;
            if (int'(sum) != exp_sum(va, vb, vc, vd) || ov !== exp_ov(va, vb, vc, vd)) begin
                n_errors++;
                $display("FAIL sweep %0d+%0d+%0d+%0d: sum=%0d ov=%b, want sum=%0d ov=%b",
                         va, vb, vc, vd, sum, ov, exp_sum(va, vb, vc, vd), exp_ov(va, vb, vc, vd));
            end
            if (n == 40000) begin
                #1;
                rst = 1'b0;
                #1;
                n_checks++;
                if (sum !== 4'd0 || ov !== 1'b0) begin
                    n_errors++;
                    $display("FAIL midstream_reset: sum=%0d ov=%b, want sum=0 ov=0", sum, ov);
                end
                rst = 1'b1;
                #1;
                n_checks++;
                if (sum !== 4'd0 || ov !== 1'b0) begin
                    n_errors++;
                    $display("FAIL reset_no_replay: sum=%0d ov=%b, want sum=0 ov=0", sum, ov);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_overflow();
        test_overflow_boundary();
        test_maximum();
        test_random();
        test_sweep_with_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/add_4.md
Name: add_4

Overview:
- Registered four-operand unsigned adder with overflow flag.
- Adds four WIDTH-bit operands a, b, c and d.
- Registers the low WIDTH bits of the total as sum, plus a flag ov when the true total does not fit in WIDTH bits.
- Used as a datapath arithmetic leaf; one-cycle latency.

Parameters:
- WIDTH, 4, bit width of each operand and of sum. The test plan values assume WIDTH=4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand 0, unsigned.
- b  input  WIDTH  operand 1, unsigned.
- c  input  WIDTH  operand 2, unsigned.
- d  input  WIDTH  operand 3, unsigned.
- sum  output  WIDTH  registered (a+b+c+d) mod 2^WIDTH.
- ov  output  1  registered overflow flag: 1 when a+b+c+d >= 2^WIDTH.

Behaviour:
- Reset:
  - rst low forces sum=0 and ov=0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while rst is low.
  - The first capture happens on the first rising clk edge after rst goes high.
- Arithmetic:
  - Internal total is WIDTH+2 bits wide, so no information is lost. The maximum total is 4*(2^WIDTH-1); for WIDTH=4 that is 60.
  - sum = total[WIDTH-1:0].
  - ov = OR of total[WIDTH+1:WIDTH].
- Latency:
  - Operands sampled on rising edge k appear on sum and ov after edge k.
  - Outputs hold until the next edge.
  - No handshake; a new operand set is accepted every cycle.
- Structure of the combinational path:
  - Carry-save stage 1: full adders on (a,b,c) give s1 and c1.
  - Carry-save stage 2: full adders on (s1, c1<<1, d) give s2 and c2.
  - Final ripple-carry adder on s2 + (c2<<1), WIDTH+2 bits wide.
  - Bits shifted in are 0.
- Boundary cases:
  - All operands 0 gives sum=0, ov=0.
  - Total exactly 2^WIDTH-1 gives ov=0.
  - Total exactly 2^WIDTH gives sum=0, ov=1.
  - All operands at maximum gives sum=12, ov=1 (WIDTH=4).
- Reset mid-operation: asserting rst clears the outputs asynchronously. The in-flight result is discarded and not replayed after reset.
- No X-propagation masking: X on an input may produce X on the outputs.

Decomposition:
- Package add_4_pkg:
  - localparam SUM_W = WIDTH+2.
  - Function ref_add4(a,b,c,d) returning {ov,sum}, for use as the verification model.
- Sub-module full_adder (1-bit; inputs x, y, cin; outputs s, cout).
  - Instantiated in generate loops for both CSA stages and the final ripple adder.
- Output register lives in add_4 itself.

Test Plan:
- Reset: hold rst=0 for 3 cycles with a=b=c=d=15 -> sum=0, ov=0 throughout. Release rst -> after the next edge, sum=12, ov=1.
- No overflow: a=15, b=c=d=0 -> sum=15, ov=0. Then a=3, b=4, c=5, d=2 -> sum=14, ov=0.
- Overflow boundary: a=15, b=1, c=0, d=0 -> sum=0, ov=1. Then a=8, b=4, c=2, d=1 -> sum=15, ov=0.
- Maximum: a=b=c=d=15 -> sum=12, ov=1. Then a=b=c=d=8 -> sum=0, ov=1.
- Exhaustive sweep:
  - Increment a every cycle, carry into b, then c, then d (65536 combinations, one per cycle).
  - Compare each result one cycle later against ref_add4; zero mismatches required.
- Reset mid-stream: during the sweep, pulse rst low between clock edges -> outputs drop to 0 immediately and resume correct one-cycle-latency results after release.
